// File: rtl/store_pkg.sv
// Shared size codes, FSM states and the byte-lane mask helper for the store narrowing path.
// Imported by store_lane_shifter and store_narrow_unit.
package store_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_BEAT0  = 2'b01,
    ST_BEAT1  = 2'b10,
    ST_RETIRE = 2'b11
  } state_e;

  // Unshifted byte mask for an access size; reserved size enables nothing.
  function automatic logic [7:0] size_mask(size_e sz);
    logic [7:0] m;
    case (sz)
      SZ_BYTE: m = 8'b0000_0001;
      SZ_HALF: m = 8'b0000_0011;
      SZ_WORD: m = 8'b0000_1111;
      default: m = 8'b0000_0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/store_lane_shifter.sv
// Combinational lane placement: shifts store data to its byte offset across a two-word window,
// builds the 8-lane byte mask, flags word-crossing accesses and narrowing overflow.
import store_pkg::*;

module store_lane_shifter (
  input  logic [31:0] data_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic        arith_i,
  output logic [63:0] shifted_o,
  output logic [7:0]  be8_o,
  output logic        ovf_o,
  output logic        split_o
);

  size_e sz;
  assign sz = size_e'(size_i);

  always_comb begin
    shifted_o = {32'b0, data_i} << {off_i, 3'b000};
    be8_o     = size_mask(sz) << off_i;
    split_o   = |be8_o[7:4];
    ovf_o     = 1'b0;
    // Signed narrowing is lossless only when the dropped bits replicate the new sign bit.
    case (sz)
      SZ_BYTE: ovf_o = arith_i ? !((&data_i[31:7]) || !(|data_i[31:7])) : |data_i[31:8];
      SZ_HALF: ovf_o = arith_i ? !((&data_i[31:15]) || !(|data_i[31:15])) : |data_i[31:16];
      default: ovf_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/store_narrow_unit.sv
// Store narrowing unit: accepts one store, issues one or two word-aligned write beats, then retires.
// STORE_MISALIGN_TRAP_EN: misaligned half/word stores retire with err instead of being split.
import store_pkg::*;

module store_narrow_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic [1:0]        req_size,
  input  logic              req_arith,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  output logic              done,
  output logic              ovf,
  output logic              err
);

  state_e state_q, state_d;

  logic              mem_valid_q, mem_valid_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              err_q, err_d;

  // Upper half of the lane window, kept for the second beat of a split store.
  logic [31:0]       hi_wdata_q, hi_wdata_d;
  logic [3:0]        hi_be_q, hi_be_d;
  logic              split_q, split_d;
  logic              ovf_pend_q, ovf_pend_d;

  logic [63:0]       sh_data;
  logic [7:0]        sh_be8;
  logic              sh_ovf;
  logic              sh_split;
  logic              misalign;
  logic              req_err;
  size_e             req_sz;

  assign req_sz = size_e'(req_size);

  store_lane_shifter u_shifter (
    .data_i    (req_data),
    .size_i    (req_size),
    .off_i     (req_addr[1:0]),
    .arith_i   (req_arith),
    .shifted_o (sh_data),
    .be8_o     (sh_be8),
    .ovf_o     (sh_ovf),
    .split_o   (sh_split)
  );

`ifdef STORE_MISALIGN_TRAP_EN
  assign misalign = ((req_sz == SZ_HALF) && req_addr[0]) ||
                    ((req_sz == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign req_err   = (req_sz == SZ_RSVD) || misalign;
  assign req_ready = (state_q == ST_IDLE);

  always_comb begin
    state_d     = state_q;
    mem_valid_d = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    mem_be_d    = '0;
    done_d      = 1'b0;
    ovf_d       = 1'b0;
    err_d       = 1'b0;
    hi_wdata_d  = hi_wdata_q;
    hi_be_d     = hi_be_q;
    split_d     = split_q;
    ovf_pend_d  = ovf_pend_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_err) begin
            state_d = ST_RETIRE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d     = ST_BEAT0;
            mem_valid_d = 1'b1;
            mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
            mem_wdata_d = sh_data[31:0];
            mem_be_d    = sh_be8[3:0];
            hi_wdata_d  = sh_data[63:32];
            hi_be_d     = sh_be8[7:4];
            split_d     = sh_split;
            ovf_pend_d  = sh_ovf;
          end
        end
      end
      ST_BEAT0: begin
        if (mem_ready && split_q) begin
          state_d     = ST_BEAT1;
          mem_valid_d = 1'b1;
          mem_addr_d  = mem_addr_q + ADDR_W'(4);
          mem_wdata_d = hi_wdata_q;
          mem_be_d    = hi_be_q;
        end else if (mem_ready) begin
          state_d = ST_RETIRE;
          done_d  = 1'b1;
          ovf_d   = ovf_pend_q;
        end else begin
          mem_valid_d = 1'b1;
          mem_addr_d  = mem_addr_q;
          mem_wdata_d = mem_wdata_q;
          mem_be_d    = mem_be_q;
        end
      end
      ST_BEAT1: begin
        if (mem_ready) begin
          state_d = ST_RETIRE;
          done_d  = 1'b1;
          ovf_d   = ovf_pend_q;
        end else begin
          mem_valid_d = 1'b1;
          mem_addr_d  = mem_addr_q;
          mem_wdata_d = mem_wdata_q;
          mem_be_d    = mem_be_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      hi_wdata_q  <= '0;
      hi_be_q     <= '0;
      split_q     <= 1'b0;
      ovf_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
      hi_wdata_q  <= hi_wdata_d;
      hi_be_q     <= hi_be_d;
      split_q     <= split_d;
      ovf_pend_q  <= ovf_pend_d;
    end
  end

  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign done      = done_q;
  assign ovf       = ovf_q;
  assign err       = err_q;

endmodule

// File: tb/tb_store_narrow_unit.sv
// Directed bench for store_narrow_unit: hand-computed beats, retire flags, stalls and reset abort.
// Checks follow STORE_MISALIGN_TRAP_EN when the bench is built with it.
module tb_store_narrow_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        req_arith;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        done;
  logic        ovf;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  store_narrow_unit #(.ADDR_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_size  (req_size),
    .req_arith (req_arith),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .done      (done),
    .ovf       (ovf),
    .err       (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request for one cycle; on return the DUT is in the cycle after acceptance.
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                       input logic ar);
    chk("req_ready_before_issue", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    req_size  = s;
    req_arith = ar;
    tick();
    req_valid = 1'b0;
    req_addr  = 32'hDEAD_BEEF;
    req_data  = 32'hFFFF_FFFF;
  endtask

  task automatic chk_beat(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be);
    chk({tag, "_valid"}, {31'b0, mem_valid}, 32'd1);
    chk({tag, "_addr"}, mem_addr, a);
    chk({tag, "_wdata"}, mem_wdata, d);
    chk({tag, "_be"}, {28'b0, mem_be}, {28'b0, be});
    chk({tag, "_done"}, {31'b0, done}, 32'd0);
    chk({tag, "_ready"}, {31'b0, req_ready}, 32'd0);
  endtask

  task automatic chk_retire(input string tag, input logic o, input logic e);
    chk({tag, "_done"}, {31'b0, done}, 32'd1);
    chk({tag, "_ovf"}, {31'b0, ovf}, {31'b0, o});
    chk({tag, "_err"}, {31'b0, err}, {31'b0, e});
    chk({tag, "_memvalid"}, {31'b0, mem_valid}, 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    req_size  = '0;
    req_arith = 1'b0;
    mem_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_be", {28'b0, mem_be}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_ovf", {31'b0, ovf}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);

    // SB at offset 3, zero-wait: beat at N+1, done at N+2.
    issue(32'h0000_1003, 32'h0000_00AB, 2'b00, 1'b0);
    chk_beat("sb", 32'h0000_1000, 32'hAB00_0000, 4'b1000);
    tick();
    chk_retire("sb_ret", 1'b0, 1'b0);
    tick();
    chk("sb_idle_ready", {31'b0, req_ready}, 32'd1);
    chk("sb_done_pulse", {31'b0, done}, 32'd0);

    // SH signed fits, then unsigned overflows back-to-back.
    issue(32'h0000_2002, 32'hFFFF_8001, 2'b01, 1'b1);
    chk_beat("sh_s", 32'h0000_2000, 32'h8001_0000, 4'b1100);
    tick();
    chk_retire("sh_s_ret", 1'b0, 1'b0);
    tick();
    issue(32'h0000_2002, 32'hFFFF_8001, 2'b01, 1'b0);
    chk_beat("sh_u", 32'h0000_2000, 32'h8001_0000, 4'b1100);
    tick();
    chk_retire("sh_u_ret", 1'b1, 1'b0);
    tick();

    // Misaligned SW: split into two beats, or trapped.
    issue(32'h0000_3001, 32'h1122_3344, 2'b10, 1'b0);
`ifdef STORE_MISALIGN_TRAP_EN
    chk_retire("sw_trap", 1'b0, 1'b1);
`else
    chk_beat("sw_b0", 32'h0000_3000, 32'h2233_4400, 4'b1110);
    tick();
    chk_beat("sw_b1", 32'h0000_3004, 32'h0000_0011, 4'b0001);
    tick();
    chk_retire("sw_ret", 1'b0, 1'b0);
`endif
    tick();

    // SB signed overflow with mem_ready held low for three cycles.
    mem_ready = 1'b0;
    issue(32'h0000_4000, 32'h1234_5678, 2'b00, 1'b1);
    chk_beat("stall0", 32'h0000_4000, 32'h1234_5678, 4'b0001);
    tick();
    chk_beat("stall1", 32'h0000_4000, 32'h1234_5678, 4'b0001);
    tick();
    chk_beat("stall2", 32'h0000_4000, 32'h1234_5678, 4'b0001);
    mem_ready = 1'b1;
    tick();
    chk_retire("stall_ret", 1'b1, 1'b0);
    tick();

    // Reserved size: error, no beat, done at N+1.
    issue(32'h0000_5000, 32'h0000_00FF, 2'b11, 1'b0);
    chk_retire("rsvd", 1'b0, 1'b1);
    chk("rsvd_ready", {31'b0, req_ready}, 32'd0);
    tick();
    chk("rsvd_idle", {31'b0, req_ready}, 32'd1);

    // SW at top of address space: second beat wraps to zero.
    issue(32'hFFFF_FFFE, 32'hAABB_CCDD, 2'b10, 1'b0);
`ifdef STORE_MISALIGN_TRAP_EN
    chk_retire("wrap_trap", 1'b0, 1'b1);
`else
    chk_beat("wrap_b0", 32'hFFFF_FFFC, 32'hCCDD_0000, 4'b1100);
    tick();
    chk_beat("wrap_b1", 32'h0000_0000, 32'h0000_AABB, 4'b0011);
    tick();
    chk_retire("wrap_ret", 1'b0, 1'b0);
`endif
    tick();

    // Reset while a beat is stalled: abort without completion.
`ifdef STORE_MISALIGN_TRAP_EN
    mem_ready = 1'b0;
    issue(32'h0000_6002, 32'h0000_BEEF, 2'b01, 1'b0);
    chk_beat("rstmid_b0", 32'h0000_6000, 32'hBEEF_0000, 4'b1100);
    tick();
`else
    issue(32'h0000_6003, 32'h0000_BEEF, 2'b01, 1'b0);
    chk_beat("rstmid_b0", 32'h0000_6000, 32'hEF00_0000, 4'b1000);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk_beat("rstmid_b1", 32'h0000_6004, 32'h0000_00BE, 4'b0001);
    tick();
    chk_beat("rstmid_b1_hold", 32'h0000_6004, 32'h0000_00BE, 4'b0001);
`endif
    reset = 1'b1;
    tick();
    chk("rstmid_memvalid", {31'b0, mem_valid}, 32'd0);
    chk("rstmid_ready", {31'b0, req_ready}, 32'd1);
    chk("rstmid_done", {31'b0, done}, 32'd0);
    reset     = 1'b0;
    mem_ready = 1'b1;
    tick();
    chk("rstmid_done_after", {31'b0, done}, 32'd0);
    chk("rstmid_memvalid_after", {31'b0, mem_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
